uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- UART receiver for the RXD pin of z80_mini_com: 8 data bits, no parity, 1 stop bit, LSB first, idle-high line.
- Samples each bit at mid-bit, checks framing, and pushes good bytes into a small first-word-fall-through FIFO.
- The CPU I/O decode reads bytes from the FIFO and polls the status flags.

Parameters:
- CLKS_PER_BIT, 2500, CLK24M cycles per UART bit (24 MHz / 9600 baud); must be >= 4.
- FIFO_AW, 2, FIFO address width; depth is 2**FIFO_AW = 4 entries.

Ports:
- CLK24M  in  1  system clock; all logic is on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- RXD  in  1  serial input, asynchronous to CLK24M.
- RD  in  1  one-cycle pop strobe from the CPU I/O decode.
- ERR_CLR  in  1  one-cycle clear of the sticky error flags.
- RDATA  out  8  FIFO head byte; 8'h00 when the FIFO is empty.
- RX_READY  out  1  FIFO not empty.
- COUNT  out  FIFO_AW+1  FIFO occupancy, 0..2**FIFO_AW.
- FRAME_ERR  out  1  sticky: a stop bit was sampled low.
- OVERRUN  out  1  sticky: a byte was dropped because the FIFO was full.

Behaviour:
- Reset (asynchronous, RST high):
  - RXD synchroniser flops = 1; FSM = IDLE; bit counter and clock counter = 0.
  - FIFO pointers = 0, so RDATA = 8'h00, RX_READY = 0, COUNT = 0.
  - FRAME_ERR = 0, OVERRUN = 0.
  - Reset during a frame abandons it; nothing partial is pushed.
  - After reset, a line already low is not treated as a start bit until it has been seen high.
- Input: RXD passes through a 2-flop synchroniser (rxs). The FSM uses only rxs.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - Detect start on rxs = 0 while the previous sample was 1.
  - Load the clock counter with CLKS_PER_BIT/2 - 1 and go to START.
- START, at counter expiry (mid start bit):
  - rxs = 0: reload CLKS_PER_BIT - 1, clear the bit index, go to DATA.
  - rxs = 1: treat as a glitch and return to IDLE; no flag is set.
- DATA:
  - At each expiry, shift rxs into bit[index] (LSB first) and reload CLKS_PER_BIT - 1.
  - After bit 7, go to STOP.
- STOP, at expiry (mid stop bit):
  - rxs = 1: request a push of the byte and go to IDLE immediately. Back-to-back frames with zero idle time must be received.
  - rxs = 0: set FRAME_ERR, discard the byte, go to BREAK.
- BREAK: wait for rxs = 1, then go to IDLE.
- Latency: the byte is at the FIFO head and RX_READY = 1 on the cycle after the mid-stop sample. The nominal total is 9.5 bit times + 3 cycles from the start-bit falling edge at the pin.
- FIFO:
  - First-word fall-through: RDATA combinationally shows mem[rd_ptr] when COUNT > 0.
  - RD with COUNT > 0 pops; RDATA and COUNT update on the next cycle.
  - RD with COUNT = 0 is ignored: no pointer change, no flag.
  - Push with COUNT < depth stores the byte.
  - Push with COUNT = depth and no RD in the same cycle: byte dropped, OVERRUN set, existing contents untouched.
  - Push and RD in the same cycle at any COUNT, including full: both succeed; COUNT is unchanged.
  - Pointers wrap modulo depth. COUNT never exceeds depth and never underflows.
- Sticky flags:
  - FRAME_ERR and OVERRUN are cleared by ERR_CLR.
  - If a set event and ERR_CLR occur in the same cycle, the set wins and the flag stays 1.
  - Errors never block reception.

Test Plan (CLKS_PER_BIT = 16 unless stated):
- Send 8'h41 with correct framing -> RX_READY rises one cycle after the mid-stop sample; RDATA = 8'h41; COUNT = 1. Pulse RD -> COUNT = 0, RDATA = 8'h00, flags = 0.
- Send 8'h01, 8'h02, 8'h03, 8'h04, 8'h05 back-to-back, no RD -> COUNT = 4, RDATA = 8'h01, OVERRUN = 1. Four RD pops return 8'h01 to 8'h04 in order; 8'h05 is absent. Pulse ERR_CLR -> OVERRUN = 0.
- With FIFO full, assert RD in the exact cycle of a push -> COUNT stays 4, OVERRUN = 0, new byte appears last.
- Drive RXD low for 4 cycles, then high -> FSM returns to IDLE; COUNT = 0, no flags set.
- Send 8'hA5 with stop bit 0, hold RXD low for 40 cycles, then send 8'h3C normally -> FRAME_ERR = 1; only 8'h3C is in the FIFO.
- Assert RST during DATA of 8'hFF, release, send 8'h55 -> only 8'h55 is received. With CLKS_PER_BIT = 2500 and CLK24M period 41.67 ns, send 8'h41 at 9600 baud -> RDATA = 8'h41.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, LSB first, idle-high) feeding a small first-word-fall-through FIFO.
// Framing errors and FIFO overruns are latched in sticky flags cleared by ERR_CLR.
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 2500,
  parameter int unsigned FIFO_AW      = 2
) (
  input  logic               CLK24M,
  input  logic               RST,
  input  logic               RXD,
  input  logic               RD,
  input  logic               ERR_CLR,
  output logic [7:0]         RDATA,
  output logic               RX_READY,
  output logic [FIFO_AW:0]   COUNT,
  output logic               FRAME_ERR,
  output logic               OVERRUN
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW    = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]      HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]      FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0]   DEPTH_C   = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t state, state_nxt;

  logic rx_meta, rxs, rx_prev;
  logic [1:0] sync_vld;
  logic [CW-1:0] clk_cnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic expired;
  logic load_half, load_full, shift_en, push_req, ferr_set;

  logic [7:0] mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic fifo_empty, fifo_full, push_ok, pop;

  // rx_prev only reports high once the synchroniser holds real line samples,
  // so a line already low at reset release never forms a falling edge.
  always_ff @(posedge CLK24M or posedge RST) begin
    if (RST) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rx_prev  <= 1'b0;
      sync_vld <= '0;
    end else begin
      rx_meta  <= RXD;
      rxs      <= rx_meta;
      rx_prev  <= rxs & sync_vld[1];
      sync_vld <= {sync_vld[0], 1'b1};
    end
  end

  assign expired = (clk_cnt == '0);

  always_ff @(posedge CLK24M or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!rxs && rx_prev) state_nxt = S_START;
      S_START: if (expired) state_nxt = rxs ? S_IDLE : S_DATA;
      S_DATA:  if (expired && bit_idx == 3'd7) state_nxt = S_STOP;
      S_STOP:  if (expired) state_nxt = rxs ? S_IDLE : S_BREAK;
      S_BREAK: if (rxs) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    load_half = 1'b0;
    load_full = 1'b0;
    shift_en  = 1'b0;
    push_req  = 1'b0;
    ferr_set  = 1'b0;
    case (state)
      S_IDLE:  load_half = !rxs && rx_prev;
      S_START: load_full = expired && !rxs;
      S_DATA: begin
        shift_en  = expired;
        load_full = expired;
      end
      S_STOP: begin
        push_req = expired && rxs;
        ferr_set = expired && !rxs;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK24M or posedge RST) begin
    if (RST) begin
      clk_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (load_half)        clk_cnt <= HALF_LOAD;
      else if (load_full)   clk_cnt <= FULL_LOAD;
      else if (!expired)    clk_cnt <= clk_cnt - CW'(1);

      if (state != S_DATA)  bit_idx <= '0;
      else if (shift_en)    bit_idx <= bit_idx + 3'd1;

      if (shift_en)         shreg[bit_idx] <= rxs;
    end
  end

  assign fifo_empty = (COUNT == '0);
  assign fifo_full  = (COUNT == DEPTH_C);
  assign pop        = RD && !fifo_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok    = push_req && (!fifo_full || RD);

  always_ff @(posedge CLK24M) begin
    if (push_ok) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge CLK24M or posedge RST) begin
    if (RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      COUNT     <= '0;
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)     rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({push_ok, pop})
        2'b10:   COUNT <= COUNT + (FIFO_AW + 1)'(1);
        2'b01:   COUNT <= COUNT - (FIFO_AW + 1)'(1);
        default: COUNT <= COUNT;
      endcase

      if (ferr_set)     FRAME_ERR <= 1'b1;
      else if (ERR_CLR) FRAME_ERR <= 1'b0;

      if (push_req && !push_ok) OVERRUN <= 1'b1;
      else if (ERR_CLR)         OVERRUN <= 1'b0;
    end
  end

  assign RDATA    = fifo_empty ? '0 : mem[rd_ptr];
  assign RX_READY = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a fast-baud instance for framing/FIFO cases
// and a 9600-baud instance on a 24 MHz clock.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int unsigned CPB = 16;

  logic       clk = 1'b0;
  logic       rst, rxd, rd, err_clr;
  logic [7:0] rdata;
  logic       rdy, ferr, ovr;
  logic [2:0] count;

  logic       rxd_b;
  logic [7:0] rdata_b;
  logic       rdy_b, ferr_b, ovr_b;
  logic [2:0] count_b;

  int checks   = 0;
  int failures = 0;

  always #20.835 clk = ~clk;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(2)) u_dut (
    .CLK24M(clk), .RST(rst), .RXD(rxd), .RD(rd), .ERR_CLR(err_clr),
    .RDATA(rdata), .RX_READY(rdy), .COUNT(count), .FRAME_ERR(ferr), .OVERRUN(ovr)
  );

  uart_rx_fifo #(.CLKS_PER_BIT(2500), .FIFO_AW(2)) u_dut_b (
    .CLK24M(clk), .RST(rst), .RXD(rxd_b), .RD(1'b0), .ERR_CLR(1'b0),
    .RDATA(rdata_b), .RX_READY(rdy_b), .COUNT(count_b), .FRAME_ERR(ferr_b), .OVERRUN(ovr_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives start + 8 data bits, then leaves RXD at the stop level.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop;
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_frame(d, 1'b1);
    repeat (CPB) @(negedge clk);
  endtask

  task automatic pop;
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic pulse_clr;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rxd = 1'b1; rxd_b = 1'b1; rd = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_count", 32'(count), 32'd0);
    check("rst_rdy",   32'(rdy),   32'd0);
    check("rst_rdata", 32'(rdata), 32'h00);
    check("rst_ferr",  32'(ferr),  32'd0);
    check("rst_ovr",   32'(ovr),   32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single byte with exact push latency
    send_frame(8'h41, 1'b1);
    repeat (10) @(negedge clk);
    check("lat_before", 32'(rdy), 32'd0);
    @(negedge clk);
    check("lat_rdy",   32'(rdy),   32'd1);
    check("b41_rdata", 32'(rdata), 32'h41);
    check("b41_count", 32'(count), 32'd1);
    repeat (5) @(negedge clk);
    pop();
    check("pop_count", 32'(count), 32'd0);
    check("pop_rdata", 32'(rdata), 32'h00);
    check("pop_ferr",  32'(ferr),  32'd0);
    check("pop_ovr",   32'(ovr),   32'd0);

    // Five back-to-back bytes; ERR_CLR coincides with the overrun
    for (int i = 1; i <= 4; i++) send_byte(8'(i));
    send_frame(8'h05, 1'b1);
    repeat (10) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("ovr_set_wins", 32'(ovr),   32'd1);
    check("ovr_count",    32'(count), 32'd4);
    check("ovr_head",     32'(rdata), 32'h01);
    repeat (5) @(negedge clk);
    for (int i = 1; i <= 4; i++) begin
      check("ovr_order", 32'(rdata), 32'(i));
      pop();
    end
    check("ovr_drained", 32'(count), 32'd0);
    check("ovr_empty",   32'(rdata), 32'h00);
    pulse_clr();
    check("ovr_clr", 32'(ovr), 32'd0);

    // Push and pop in the same cycle while full
    for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i));
    check("full_count", 32'(count), 32'd4);
    send_frame(8'h14, 1'b1);
    repeat (10) @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    check("pp_count", 32'(count), 32'd4);
    check("pp_ovr",   32'(ovr),   32'd0);
    check("pp_head",  32'(rdata), 32'h11);
    repeat (5) @(negedge clk);
    for (int i = 1; i <= 4; i++) begin
      check("pp_order", 32'(rdata), 32'h10 + 32'(i));
      pop();
    end
    check("pp_drained", 32'(count), 32'd0);

    // Short glitch is not a start bit
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (30) @(negedge clk);
    check("gl_count", 32'(count), 32'd0);
    check("gl_ferr",  32'(ferr),  32'd0);
    check("gl_ovr",   32'(ovr),   32'd0);

    // Framing error (set wins over ERR_CLR), break, then recovery
    send_frame(8'hA5, 1'b0);
    repeat (10) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("fe_set_wins", 32'(ferr),  32'd1);
    check("fe_count",    32'(count), 32'd0);
    repeat (45) @(negedge clk);
    rxd = 1'b1;
    repeat (8) @(negedge clk);
    send_byte(8'h3C);
    check("fe_ferr",  32'(ferr),  32'd1);
    check("fe_count2", 32'(count), 32'd1);
    check("fe_rdata", 32'(rdata), 32'h3C);
    pop();
    pulse_clr();
    check("fe_clr", 32'(ferr), 32'd0);

    // Line held low across reset release must not start a frame
    rxd = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    check("lowrst_count", 32'(count), 32'd0);
    check("lowrst_ferr",  32'(ferr),  32'd0);

    // Reset in the middle of a frame abandons it
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_count", 32'(count), 32'd0);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    send_byte(8'h55);
    check("midrst_only55", 32'(count), 32'd1);
    check("midrst_rdata",  32'(rdata), 32'h55);
    check("midrst_ferr",   32'(ferr),  32'd0);
    pop();

    // 9600 baud on the 24 MHz clock
    rxd_b = 1'b0;
    repeat (2500) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd_b = 1'(8'h41 >> i);
      repeat (2500) @(negedge clk);
    end
    rxd_b = 1'b1;
    repeat (2500) @(negedge clk);
    check("b9600_rdy",   32'(rdy_b),   32'd1);
    check("b9600_count", 32'(count_b), 32'd1);
    check("b9600_rdata", 32'(rdata_b), 32'h41);
    check("b9600_ferr",  32'(ferr_b),  32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
